// File: rtl/trap_pkg.sv
// trap_pkg: shared CSR addresses, mstatus bit positions,
// trap FSM state enum and the interrupt cause helper.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // external line i lives at mie/mip bit IRQ_BASE+i
  localparam int IRQ_BASE = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP,
    ST_MRET,
    ST_FLUSH
  } trap_state_e;

  function automatic logic [4:0] irq_code(input logic [3:0] k);
    return 5'(IRQ_BASE) + {1'b0, k};
  endfunction

  function automatic logic [31:0] irq_cause(input logic [3:0] k);
    return {1'b1, 26'b0, irq_code(k)};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchroniser.
// Ports: clk, reset (async high), d_i (async in), q_o (synced out).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ff1_q;
  logic [W-1:0] ff2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode interrupt CSRs plus trap/mret FSM.
// Ports: clk, reset, irq, csr_* access, is_mret/inst_valid/inst_pc
// from commit; intr_exc, mret_take, redirect_pc to the datapath.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter bit          VECTOR_EN  = 1'b1,
  parameter logic [31:0] RESET_TVEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               csr_reg_wr,
  input  logic               csr_reg_rd,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic               is_mret,
  input  logic               inst_valid,
  input  logic [31:0]        inst_pc,
  output logic               intr_exc,
  output logic               mret_take,
  output logic [31:0]        redirect_pc
);

  localparam logic [31:0] TVEC_MASK =
    VECTOR_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic [NUM_IRQ-1:0] irq_s;

  sync_2ff #(.W(NUM_IRQ)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (irq),
    .q_o   (irq_s)
  );

  trap_state_e state_q;

  logic               st_mie_q, st_mie_d;
  logic               st_mpie_q, st_mpie_d;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;

  logic [NUM_IRQ-1:0] pend;
  logic [3:0]         k;
  logic               take_trap;
  logic               take_mret;
  logic [31:0]        tvec_base;
  logic [31:0]        trap_tgt;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
  logic hit_mstatus, hit_mie, hit_mtvec;
  logic hit_mepc, hit_mcause, hit_mip;

  logic [31:0] mstatus_w, mie_w, mip_w;

  assign pend = irq_s & ie_q;

  // lowest pending-enabled line wins
  always_comb begin
    k = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) k = 4'(i);
    end
  end

  // evaluation uses the CSR values held before any write this cycle
  assign take_mret = (state_q == ST_IDLE) && is_mret && inst_valid;
  assign take_trap = (state_q == ST_IDLE) && inst_valid
                  && st_mie_q && (|pend) && !is_mret;

  assign tvec_base = mtvec_q & 32'hFFFF_FFFC;
  assign trap_tgt  = mtvec_q[0]
                   ? tvec_base + {25'b0, irq_code(k), 2'b00}
                   : tvec_base;

  assign hit_mstatus = (csr_addr == CSR_MSTATUS);
  assign hit_mie     = (csr_addr == CSR_MIE);
  assign hit_mtvec   = (csr_addr == CSR_MTVEC);
  assign hit_mepc    = (csr_addr == CSR_MEPC);
  assign hit_mcause  = (csr_addr == CSR_MCAUSE);
  assign hit_mip     = (csr_addr == CSR_MIP);

  assign wr_mstatus = csr_reg_wr && hit_mstatus;
  assign wr_mie     = csr_reg_wr && hit_mie;
  assign wr_mtvec   = csr_reg_wr && hit_mtvec;
  assign wr_mepc    = csr_reg_wr && hit_mepc;
  assign wr_mcause  = csr_reg_wr && hit_mcause;

  always_comb begin
    mstatus_w = '0;
    mstatus_w[MSTATUS_MIE]  = st_mie_q;
    mstatus_w[MSTATUS_MPIE] = st_mpie_q;
    mie_w = '0;
    mie_w[IRQ_BASE +: NUM_IRQ] = ie_q;
    mip_w = '0;
    mip_w[IRQ_BASE +: NUM_IRQ] = irq_s;
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_reg_rd) begin
      unique case (1'b1)
        hit_mstatus: csr_rdata = mstatus_w;
        hit_mie:     csr_rdata = mie_w;
        hit_mtvec:   csr_rdata = mtvec_q;
        hit_mepc:    csr_rdata = mepc_q;
        hit_mcause:  csr_rdata = mcause_q;
        hit_mip:     csr_rdata = mip_w;
        default:     csr_rdata = '0;
      endcase
    end
  end

  // software writes first; trap/mret updates then override the
  // registers they own so the coincident write is dropped there
  always_comb begin
    st_mie_d  = st_mie_q;
    st_mpie_d = st_mpie_q;
    ie_d      = ie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (wr_mstatus) begin
      st_mie_d  = csr_wdata[MSTATUS_MIE];
      st_mpie_d = csr_wdata[MSTATUS_MPIE];
    end
    if (wr_mie)    ie_d     = csr_wdata[IRQ_BASE +: NUM_IRQ];
    if (wr_mtvec)  mtvec_d  = csr_wdata & TVEC_MASK;
    if (wr_mepc)   mepc_d   = csr_wdata & 32'hFFFF_FFFC;
    if (wr_mcause) mcause_d = csr_wdata;
    if (take_trap) begin
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      mepc_d    = inst_pc & 32'hFFFF_FFFC;
      mcause_d  = irq_cause(k);
    end else if (take_mret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      ie_q      <= '0;
      mtvec_q   <= RESET_TVEC & TVEC_MASK;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      st_mie_q  <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      ie_q      <= ie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // TRAP/MRET are the single pulse cycles; FLUSH masks evaluation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      intr_exc    <= 1'b0;
      mret_take   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      intr_exc    <= 1'b0;
      mret_take   <= 1'b0;
      redirect_pc <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (take_mret) begin
            state_q     <= ST_MRET;
            mret_take   <= 1'b1;
            redirect_pc <= mepc_q;
          end else if (take_trap) begin
            state_q     <= ST_TRAP;
            intr_exc    <= 1'b1;
            redirect_pc <= trap_tgt;
          end
        end
        ST_TRAP:  state_q <= ST_FLUSH;
        ST_MRET:  state_q <= ST_FLUSH;
        ST_FLUSH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl with a pulse
// scoreboard and immediate-assertion checks.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        csr_reg_wr, csr_reg_rd;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        is_mret, inst_valid;
  logic [31:0] inst_pc;
  logic        intr_exc, mret_take;
  logic [31:0] redirect_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          is_mret_ev;
    logic [31:0] tgt;
    int          lat;
  } exp_t;

  exp_t sb[$];

  trap_ctrl #(
    .NUM_IRQ(4),
    .VECTOR_EN(1'b1),
    .RESET_TVEC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .csr_reg_wr (csr_reg_wr),
    .csr_reg_rd (csr_reg_rd),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .is_mret    (is_mret),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .intr_exc   (intr_exc),
    .mret_take  (mret_take),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_reg_wr = 1'b1;
    csr_addr   = a;
    csr_wdata  = d;
    @(negedge clk);
    csr_reg_wr = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a,
                         input logic [31:0] exp);
    csr_reg_rd = 1'b1;
    csr_addr   = a;
    #1;
    chk(tag, csr_rdata, exp);
    csr_reg_rd = 1'b0;
  endtask

  task automatic wait_pulse();
    exp_t e;
    int   n;
    bit   got;
    n   = 0;
    got = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      is_mret    = 1'b0;
      csr_reg_wr = 1'b0;
      if (intr_exc || mret_take) got = 1'b1;
    end
    chk({e.tag, "_seen"}, 32'(got), 32'd1);
    chk({e.tag, "_kind"}, {30'b0, mret_take, intr_exc},
        e.is_mret_ev ? 32'd2 : 32'd1);
    chk({e.tag, "_tgt"}, redirect_pc, e.tgt);
    chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {30'b0, mret_take, intr_exc}, 32'd0);
    end
  endtask

  task automatic push(input string tag, input bit m,
                      input logic [31:0] t, input int lat);
    exp_t e;
    e.tag        = tag;
    e.is_mret_ev = m;
    e.tgt        = t;
    e.lat        = lat;
    sb.push_back(e);
  endtask

  initial begin
    reset      = 1'b1;
    irq        = '0;
    csr_reg_wr = 1'b0;
    csr_reg_rd = 1'b0;
    csr_addr   = '0;
    csr_wdata  = '0;
    is_mret    = 1'b0;
    inst_valid = 1'b1;
    inst_pc    = 32'h40;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_pulses", {30'b0, mret_take, intr_exc}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'h0);
    csr_chk("rst_mstatus", 12'h300, 32'h0);
    csr_chk("rst_mie", 12'h304, 32'h0);
    csr_chk("rst_mtvec", 12'h305, 32'h0);
    csr_chk("rst_mepc", 12'h341, 32'h0);
    csr_chk("rst_mcause", 12'h342, 32'h0);
    csr_chk("rst_mip", 12'h344, 32'h0);

    csr_wr(12'h304, 32'hFFFF_FFFF);
    csr_chk("mie_mask", 12'h304, 32'h000F_0000);
    csr_wr(12'h305, 32'h0000_0103);
    csr_chk("mtvec_b1", 12'h305, 32'h0000_0101);
    csr_wr(12'h341, 32'h0000_0047);
    csr_chk("mepc_lsb", 12'h341, 32'h0000_0044);
    csr_wr(12'h123, 32'hDEAD_BEEF);
    csr_chk("unimpl", 12'h123, 32'h0);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_chk("mstatus_mask", 12'h300, 32'h88);

    csr_wr(12'h304, 32'h0001_0000);
    csr_wr(12'h305, 32'h0000_0100);
    csr_wr(12'h300, 32'h0000_0008);
    csr_chk("mie_set", 12'h304, 32'h0001_0000);

    push("trap0", 1'b0, 32'h100, 3);
    irq[0] = 1'b1;
    wait_pulse();
    csr_chk("t0_mepc", 12'h341, 32'h40);
    csr_chk("t0_mcause", 12'h342, 32'h8000_0010);
    csr_chk("t0_mstatus", 12'h300, 32'h80);
    csr_chk("t0_mip", 12'h344, 32'h0001_0000);
    @(negedge clk);
    chk("t0_one_cycle", {31'b0, intr_exc}, 32'd0);
    chk("t0_redir_clr", redirect_pc, 32'h0);

    irq[0] = 1'b0;
    repeat (3) @(negedge clk);
    push("mret0", 1'b1, 32'h40, 1);
    is_mret = 1'b1;
    wait_pulse();
    csr_chk("m0_mstatus", 12'h300, 32'h88);
    @(negedge clk);
    chk("m0_one_cycle", {31'b0, mret_take}, 32'd0);
    expect_quiet("m0_quiet", 3);

    irq[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    csr_reg_wr = 1'b1;
    csr_addr   = 12'h300;
    csr_wdata  = 32'h0;
    push("trap_wr", 1'b0, 32'h100, 1);
    wait_pulse();
    csr_chk("twr_mstatus", 12'h300, 32'h80);
    csr_chk("twr_mepc", 12'h341, 32'h40);

    repeat (3) @(negedge clk);
    inst_valid = 1'b0;
    csr_wr(12'h300, 32'h88);
    expect_quiet("iv0_quiet", 2);
    is_mret    = 1'b1;
    inst_valid = 1'b1;
    push("mret_pri", 1'b1, 32'h40, 1);
    push("trap_after", 1'b0, 32'h100, 3);
    wait_pulse();
    wait_pulse();
    csr_chk("ta_mstatus", 12'h300, 32'h80);
    csr_chk("ta_mcause", 12'h342, 32'h8000_0010);

    irq = '0;
    repeat (3) @(negedge clk);
    csr_wr(12'h304, 32'h0006_0000);
    csr_wr(12'h305, 32'h0000_0101);
    csr_wr(12'h300, 32'h0000_0008);
    inst_valid = 1'b0;
    irq[1] = 1'b1;
    @(negedge clk);
    irq[1] = 1'b0;
    repeat (4) @(negedge clk);
    inst_valid = 1'b1;
    expect_quiet("drop_quiet", 5);

    inst_pc = 32'h80;
    push("trap_vec", 1'b0, 32'h144, 3);
    irq = 4'b0110;
    wait_pulse();
    csr_chk("tv_mcause", 12'h342, 32'h8000_0011);
    csr_chk("tv_mepc", 12'h341, 32'h80);
    csr_chk("tv_mip", 12'h344, 32'h0006_0000);

    irq = '0;
    repeat (3) @(negedge clk);
    csr_wr(12'h300, 32'h0000_0008);
    push("trap_rst", 1'b0, 32'h144, 3);
    irq = 4'b0010;
    wait_pulse();
    reset = 1'b1;
    #1;
    chk("ra_pulses", {30'b0, mret_take, intr_exc}, 32'd0);
    chk("ra_redirect", redirect_pc, 32'h0);
    csr_chk("ra_mstatus", 12'h300, 32'h0);
    csr_chk("ra_mie", 12'h304, 32'h0);
    csr_chk("ra_mtvec", 12'h305, 32'h0);
    csr_chk("ra_mepc", 12'h341, 32'h0);
    csr_chk("ra_mcause", 12'h342, 32'h0);
    csr_chk("ra_mip", 12'h344, 32'h0);
    irq = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_quiet("ra_quiet", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines, legal range 1..16.
REQ-002 SHALL have parameter VECTOR_EN, default 1, enabling vectored mtvec mode when 1.
REQ-003 SHALL have parameter RESET_TVEC, default 32'h0000_0000, reset value of mtvec.
REQ-004 SHALL have ports: clk input 1 (the single clock); reset input 1 (asynchronous, active-high).
REQ-005 SHALL have irq input NUM_IRQ: level-sensitive external interrupt requests, asynchronous to clk.
REQ-006 SHALL have csr_reg_wr input 1 (CSR write strobe) and csr_reg_rd input 1 (CSR read strobe).
REQ-007 SHALL have csr_addr input 12 and csr_wdata input 32.
REQ-008 SHALL have csr_rdata output 32: combinational read data.
REQ-009 SHALL have is_mret input 1 (mret at commit) and inst_valid input 1 (commit slot holds a valid instruction).
REQ-010 SHALL have inst_pc input 32: PC of the committing instruction.
REQ-011 SHALL have intr_exc output 1 (one-cycle trap-take pulse), mret_take output 1 (one-cycle pulse), redirect_pc output 32 (target while either pulse is high, else 0).

Function
REQ-012 SHALL implement CSRs mstatus 0x300 (MIE bit3, MPIE bit7, other bits 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only).
REQ-013 SHALL map irq[i] to mie/mip bit 16+i; unmapped mie bits read 0.
REQ-014 SHALL return 0 on reads of unimplemented addresses and ignore writes to them.
REQ-015 SHALL force mepc[1:0]=0; mtvec[1] SHALL read 0; mtvec[0] SHALL read 0 when VECTOR_EN=0.
REQ-016 SHALL pass irq through a 2-flop synchroniser; mip reflects synchroniser output.
REQ-017 SHALL run FSM states IDLE, TRAP, MRET, FLUSH.
REQ-018 IDLE->TRAP when inst_valid and mstatus.MIE and (mip & mie) nonzero and not is_mret.
REQ-019 IDLE->MRET when is_mret and inst_valid; mret SHALL win over a simultaneous pending interrupt.
REQ-020 In TRAP: intr_exc=1 for exactly one cycle; mepc<=inst_pc, mcause<={1,31'(16+k)} with k the lowest pending-enabled index; MPIE<=MIE, MIE<=0; next FLUSH.
REQ-021 redirect_pc in TRAP: mtvec base when mode 0; base+4*(16+k) when mode 1.
REQ-022 In MRET: mret_take=1 for one cycle, redirect_pc=mepc, MIE<=MPIE, MPIE<=1; next FLUSH.
REQ-023 FLUSH SHALL last one cycle with no pulse and no trap evaluation, then return to IDLE.
REQ-024 Latency: irq rising edge to intr_exc high SHALL be 3 clk cycles minimum (2 sync + 1 FSM), given MIE, mie bit and inst_valid set.
REQ-025 A CSR write coincident with the trap or mret state update SHALL be discarded for the registers that update updates; other CSR writes apply.
REQ-026 Trap evaluation SHALL use pre-write CSR values of the same cycle.
REQ-027 Interrupt deasserted before TRAP is entered SHALL not be taken; once in TRAP, cause is latched.

Reset
REQ-028 On reset: mstatus, mie, mepc, mcause, synchroniser flops = 0; mtvec=RESET_TVEC; FSM=IDLE; intr_exc=0, mret_take=0, redirect_pc=0.
REQ-029 Reset asserted mid-TRAP/MRET SHALL abort immediately with no pulse after deassertion.

Structure
REQ-030 CSR address constants, mstatus bit positions and FSM state enum SHALL live in the shared package trap_pkg.
REQ-031 The synchroniser SHALL be a sub-module sync_2ff, width-parametrised.
REQ-032 trap_ctrl SHALL connect into pipeline in place of the existing intr_exc/is_mret path, driving the datapath redirect.

Verification
REQ-033 Write mie=0x0001_0000, mstatus=0x8, mtvec=0x100; raise irq[0] with inst_pc=0x40 -> intr_exc at cycle 3, redirect_pc=0x100, mepc=0x40, mcause=0x8000_0010, mstatus=0x80.
REQ-034 mtvec=0x101 (vectored), irq[2] and irq[1] both enabled and pending -> redirect_pc=0x100+4*17=0x144, mcause=0x8000_0011.
REQ-035 After REQ-033 trap, is_mret=1 inst_valid=1 -> mret_take one cycle, redirect_pc=0x40, mstatus=0x88.
REQ-036 is_mret and pending irq same cycle -> mret_take first, FLUSH, then intr_exc next evaluation.
REQ-037 csr write mstatus=0x0 in same cycle as trap entry -> trap taken, mstatus reads 0x80 afterwards.
REQ-038 Assert reset during TRAP -> all outputs 0, all CSRs at reset values, no pulse for 5 cycles after release with irq low.
